// File: rtl/l2_sio_rsp_arb.sv
// rtl/l2_sio_rsp_arb.sv - round-robin, credit-gated L2 bank to SIO response packet arbiter
module l2_sio_rsp_arb #(
  parameter int NBANK = 8,
  parameter int DW    = 32,
  parameter int BEATS = 17,
  parameter int NCRED = 4
) (
  input  logic                  iol2clk,
  input  logic                  reset,
  input  logic [NBANK-1:0]      l2b_req,
  input  logic [NBANK*DW-1:0]   l2b_data,
  input  logic [NBANK*2-1:0]    l2b_parity,
  input  logic [NBANK-1:0]      l2b_ue_err,
  output logic [NBANK-1:0]      l2b_gnt,
  input  logic                  sio_credit_ret,
  output logic                  sio_vld,
  output logic                  sio_ctag_vld,
  output logic [DW-1:0]         sio_data,
  output logic [1:0]            sio_parity,
  output logic                  sio_ue_err,
  output logic [2:0]            sio_bank,
  output logic                  cred_ovf,
  output logic                  proto_err
);

  localparam int BCW = $clog2(BEATS);
  localparam int CW  = $clog2(NCRED + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [2:0]     winner, winner_nxt;
  logic [2:0]     rr_ptr, rr_ptr_nxt;
  logic [2:0]     arb_win;
  logic           arb_found;
  logic [BCW-1:0] beat_cnt, beat_cnt_nxt;
  logic [CW-1:0]  cred_cnt;
  logic           arb_ok;
  logic           start;
  logic           last_beat;

  assign arb_ok    = (|l2b_req) && (cred_cnt != '0);
  assign last_beat = (beat_cnt == BCW'(BEATS - 1));

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    arb_win   = rr_ptr;
    arb_found = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      idx = (int'(rr_ptr) + i) % NBANK;
      if (!arb_found && l2b_req[idx]) begin
        arb_win   = 3'(idx);
        arb_found = 1'b1;
      end
    end
  end

  // Next-state: packets run BEATS cycles; the last beat may chain straight into the next packet.
  always_comb begin
    state_nxt    = state;
    winner_nxt   = winner;
    beat_cnt_nxt = beat_cnt;
    rr_ptr_nxt   = rr_ptr;
    start        = 1'b0;
    case (state)
      IDLE: begin
        if (arb_ok) start = 1'b1;
      end
      XFER: begin
        if (last_beat) begin
          if (arb_ok) start = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt + BCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt    = XFER;
      winner_nxt   = arb_win;
      beat_cnt_nxt = '0;
      rr_ptr_nxt   = (arb_win == 3'(NBANK - 1)) ? 3'd0 : arb_win + 3'd1;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge iol2clk) begin
    if (reset) begin
      state    <= IDLE;
      winner   <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      winner   <= winner_nxt;
      beat_cnt <= beat_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // Grant is decoded purely from registered state, so it changes only on the clock.
  always_comb begin
    l2b_gnt = '0;
    if (state == XFER) l2b_gnt[winner] = 1'b1;
  end

  // Credit counter: a start and a return in the same cycle cancel; returns saturate at NCRED.
  always_ff @(posedge iol2clk) begin
    if (reset) begin
      cred_cnt <= CW'(NCRED);
      cred_ovf <= 1'b0;
    end else if (start && !sio_credit_ret) begin
      cred_cnt <= cred_cnt - CW'(1);
    end else if (!start && sio_credit_ret) begin
      if (cred_cnt == CW'(NCRED)) cred_ovf <= 1'b1;
      else                        cred_cnt <= cred_cnt + CW'(1);
    end
  end

  // Sticky protocol error: granted bank let go of req before its final beat.
  always_ff @(posedge iol2clk) begin
    if (reset)                                             proto_err <= 1'b0;
    else if (state == XFER && !last_beat && !l2b_req[winner]) proto_err <= 1'b1;
  end

  // Outbound bus: capture the winner's beat during each grant cycle.
  always_ff @(posedge iol2clk) begin
    if (reset || state != XFER) begin
      sio_vld      <= 1'b0;
      sio_ctag_vld <= 1'b0;
      sio_data     <= '0;
      sio_parity   <= '0;
      sio_ue_err   <= 1'b0;
      sio_bank     <= '0;
    end else begin
      sio_vld      <= 1'b1;
      sio_ctag_vld <= (beat_cnt == '0);
      sio_data     <= l2b_data[winner*DW +: DW];
      sio_parity   <= l2b_parity[winner*2 +: 2];
      sio_ue_err   <= l2b_ue_err[winner];
      sio_bank     <= winner;
    end
  end

endmodule

// File: tb/tb_l2_sio_rsp_arb.sv
// tb/tb_l2_sio_rsp_arb.sv - self-checking bench for l2_sio_rsp_arb
module tb_l2_sio_rsp_arb;
  localparam int NBANK = 8;
  localparam int DW    = 32;
  localparam int BEATS = 17;
  localparam int NCRED = 4;

  logic                iol2clk = 1'b0;
  logic                reset = 1'b1;
  logic [NBANK-1:0]    l2b_req = '0;
  logic [NBANK*DW-1:0] l2b_data = '0;
  logic [NBANK*2-1:0]  l2b_parity = '0;
  logic [NBANK-1:0]    l2b_ue_err = '0;
  logic [NBANK-1:0]    l2b_gnt;
  logic                sio_credit_ret = 1'b0;
  logic                sio_vld, sio_ctag_vld, sio_ue_err, cred_ovf, proto_err;
  logic [DW-1:0]       sio_data;
  logic [1:0]          sio_parity;
  logic [2:0]          sio_bank;

  l2_sio_rsp_arb dut (
    .iol2clk(iol2clk), .reset(reset), .l2b_req(l2b_req), .l2b_data(l2b_data),
    .l2b_parity(l2b_parity), .l2b_ue_err(l2b_ue_err), .l2b_gnt(l2b_gnt),
    .sio_credit_ret(sio_credit_ret), .sio_vld(sio_vld), .sio_ctag_vld(sio_ctag_vld),
    .sio_data(sio_data), .sio_parity(sio_parity), .sio_ue_err(sio_ue_err),
    .sio_bank(sio_bank), .cred_ovf(cred_ovf), .proto_err(proto_err)
  );

  always #5 iol2clk = ~iol2clk;

  // Model: owner bank (-1 when free), beats still owed, next-priority bank, free buffers.
  int          m_bank = -1, m_left = 0, m_ptr = 0, m_cred = NCRED;
  bit          m_ovf = 0, m_perr = 0;
  logic [7:0]  e_gnt = '0;
  logic        e_vld = 0, e_ctag = 0, e_ue = 0;
  logic [31:0] e_data = '0;
  logic [1:0]  e_par = '0;
  logic [2:0]  e_bank = '0;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit cmp_en = 0;
  int vld_cnt = 0, gnt_cnt = 0, ue_cnt = 0, ue_beat = -1, beat_idx = 0;
  int ctag_bank[$];
  int ctag_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_update();
    bit started;
    started = 0;
    if (reset) begin
      m_bank = -1; m_left = 0; m_ptr = 0; m_cred = NCRED; m_ovf = 0; m_perr = 0;
      e_vld = 0; e_ctag = 0; e_ue = 0; e_data = '0; e_par = '0; e_bank = '0; e_gnt = '0;
      return;
    end
    if (m_bank >= 0) begin
      e_vld  = 1;
      e_ctag = (m_left == BEATS);
      e_data = l2b_data[m_bank*DW +: DW];
      e_par  = l2b_parity[m_bank*2 +: 2];
      e_ue   = l2b_ue_err[m_bank];
      e_bank = 3'(m_bank);
      if (m_left > 1 && !l2b_req[m_bank]) m_perr = 1;
    end else begin
      e_vld = 0; e_ctag = 0; e_ue = 0; e_data = '0; e_par = '0; e_bank = '0;
    end
    if (m_bank >= 0 && m_left > 1) begin
      m_left--;
    end else if (l2b_req != 0 && m_cred > 0) begin
      started = 1;
      for (int k = 0; k < NBANK; k++) begin
        int b;
        b = (m_ptr + k) % NBANK;
        if (started && l2b_req[b] && m_left != -99) begin
          m_bank = b;
          m_left = -99;
        end
      end
      m_left = BEATS;
      m_ptr  = (m_bank + 1) % NBANK;
    end else begin
      m_bank = -1;
    end
    if (started && !sio_credit_ret) m_cred--;
    else if (!started && sio_credit_ret) begin
      if (m_cred == NCRED) m_ovf = 1;
      else m_cred++;
    end
    e_gnt = (m_bank >= 0) ? 8'(1 << m_bank) : 8'h00;
  endtask

  task automatic step();
    @(posedge iol2clk);
    model_update();
    cyc++;
    #1;
    for (int i = 0; i < NBANK; i++) l2b_data[i*DW +: DW] = $urandom;
    l2b_parity = 16'($urandom);
  endtask

  task automatic do_reset();
    l2b_req = '0; l2b_ue_err = '0; sio_credit_ret = 0;
    reset = 1; step(); reset = 0;
  endtask

  // Cycle-by-cycle comparison against the model, plus observation counters.
  initial begin
    forever begin
      @(negedge iol2clk);
      if (cmp_en) begin
        chk("gnt", 64'(l2b_gnt), 64'(e_gnt));
        chk("sio_vld", 64'(sio_vld), 64'(e_vld));
        chk("sio_ctag_vld", 64'(sio_ctag_vld), 64'(e_ctag));
        chk("sio_data", 64'(sio_data), 64'(e_data));
        chk("sio_parity", 64'(sio_parity), 64'(e_par));
        chk("sio_ue_err", 64'(sio_ue_err), 64'(e_ue));
        chk("sio_bank", 64'(sio_bank), 64'(e_bank));
        chk("cred_ovf", 64'(cred_ovf), 64'(m_ovf));
        chk("proto_err", 64'(proto_err), 64'(m_perr));
        if (sio_ctag_vld) begin
          beat_idx = 0;
          ctag_bank.push_back(int'(sio_bank));
          ctag_cyc.push_back(cyc);
        end else if (sio_vld) beat_idx++;
        if (sio_vld) vld_cnt++;
        if (l2b_gnt != 0) gnt_cnt++;
        if (sio_ue_err) begin ue_cnt++; ue_beat = beat_idx; end
      end
    end
  end

  initial begin
    int cb, vb, gb, ub;
    step(); cmp_en = 1; step();
    reset = 0;
    chk("rst_gnt", 64'(l2b_gnt), 64'h0);
    chk("rst_vld", 64'(sio_vld), 64'h0);
    chk("rst_ovf", 64'(cred_ovf), 64'h0);

    // Single request from bank 3.
    cb = ctag_bank.size(); vb = vld_cnt; gb = gnt_cnt;
    l2b_req = 8'h08;
    step();
    chk("t1_gnt_first", 64'(l2b_gnt), 64'h08);
    chk("t1_no_ctag_yet", 64'(sio_ctag_vld), 64'h0);
    step();
    chk("t1_ctag", 64'(sio_ctag_vld), 64'h1);
    chk("t1_bank", 64'(sio_bank), 64'h3);
    repeat (BEATS - 2) step();
    l2b_req = '0;
    repeat (3) step();
    chk("t1_vld_beats", 64'(vld_cnt - vb), 64'd17);
    chk("t1_gnt_cycles", 64'(gnt_cnt - gb), 64'd17);
    chk("t1_packets", 64'(ctag_bank.size() - cb), 64'd1);
    chk("t1_proto", 64'(proto_err), 64'h0);

    // All banks request; one credit back per packet; round-robin order, no bubbles.
    do_reset();
    cb = ctag_bank.size();
    l2b_req = 8'hFF;
    for (int i = 0; i < 9 * BEATS; i++) begin
      sio_credit_ret = (i % BEATS == 3);
      l2b_ue_err = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step();
    end
    sio_credit_ret = 0; l2b_ue_err = '0;
    step();
    chk("t2_packets", 64'(ctag_bank.size() - cb >= 9), 64'h1);
    for (int k = 0; k < 9; k++) begin
      chk("t2_order", 64'(ctag_bank[cb + k]), 64'(k % NBANK));
      if (k > 0) chk("t2_spacing", 64'(ctag_cyc[cb + k] - ctag_cyc[cb + k - 1]), 64'd17);
    end

    // No credit returns: bank 0 gets four packets, the fifth waits for a return.
    do_reset();
    cb = ctag_bank.size();
    l2b_req = 8'h01;
    repeat (4 * BEATS + 5) step();
    chk("t3_four_pkts", 64'(ctag_bank.size() - cb), 64'd4);
    chk("t3_stalled", 64'(l2b_gnt), 64'h0);
    sio_credit_ret = 1; step(); sio_credit_ret = 0;
    chk("t3_not_same_cycle", 64'(l2b_gnt), 64'h0);
    step();
    chk("t3_fifth_start", 64'(l2b_gnt), 64'h01);
    repeat (BEATS - 1) step();
    l2b_req = '0;
    repeat (3) step();
    chk("t3_five_pkts", 64'(ctag_bank.size() - cb), 64'd5);
    chk("t3_proto", 64'(proto_err), 64'h0);

    // Credit overflow at full count.
    do_reset();
    sio_credit_ret = 1; step(); sio_credit_ret = 0;
    repeat (3) step();
    chk("t4_ovf", 64'(cred_ovf), 64'h1);

    // Start and return together at two credits leaves two: 2 + 3 packets total.
    do_reset();
    cb = ctag_bank.size();
    l2b_req = 8'h02; repeat (BEATS) step();
    l2b_req = 8'h02; repeat (BEATS) step();
    l2b_req = 8'h04; sio_credit_ret = 1; step(); sio_credit_ret = 0;
    repeat (3 * BEATS + 10) step();
    chk("t4_total_pkts", 64'(ctag_bank.size() - cb), 64'd5);
    chk("t4_stalled", 64'(l2b_gnt), 64'h0);
    chk("t4_no_ovf", 64'(cred_ovf), 64'h0);

    // Bank 5 drops req at beat 6 and flags UE on beat 9.
    do_reset();
    vb = vld_cnt; ub = ue_cnt;
    for (int i = 0; i < 20; i++) begin
      l2b_req    = (i < 7) ? 8'h20 : 8'h00;
      l2b_ue_err = (i == 10) ? 8'h20 : 8'h00;
      step();
    end
    l2b_ue_err = '0;
    repeat (3) step();
    chk("t5_all_beats", 64'(vld_cnt - vb), 64'd17);
    chk("t5_ue_count", 64'(ue_cnt - ub), 64'd1);
    chk("t5_ue_beat", 64'(ue_beat), 64'd9);
    chk("t5_proto", 64'(proto_err), 64'h1);

    // Reset in the middle of a packet aborts it and clears the round-robin pointer.
    do_reset();
    l2b_req = 8'h40;
    repeat (11) step();
    reset = 1; step();
    chk("t6_gnt", 64'(l2b_gnt), 64'h0);
    chk("t6_vld", 64'(sio_vld), 64'h0);
    chk("t6_data", 64'(sio_data), 64'h0);
    chk("t6_bank", 64'(sio_bank), 64'h0);
    reset = 0;
    cb = ctag_bank.size();
    l2b_req = 8'h82;
    repeat (4 * BEATS + 5) step();
    chk("t6_pkts", 64'(ctag_bank.size() - cb), 64'd4);
    chk("t6_first", 64'(ctag_bank[cb]), 64'd1);
    chk("t6_second", 64'(ctag_bank[cb + 1]), 64'd7);
    chk("t6_third", 64'(ctag_bank[cb + 2]), 64'd1);
    l2b_req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_sio_rsp_arb.md
# l2_sio_rsp_arb

Outbound response arbiter between the eight L2 banks and the SIO on the iol2clk domain. Each bank requests the shared L2-to-SIO return path for a fixed-length response packet (one ctag header beat plus 16 data beats). The block grants one bank at a time in round-robin order, holds the grant for the whole packet, and muxes the winner's data, parity and UE onto one registered outbound bus. Packet starts are gated by SIO buffer credits.

## Interface
Parameters:
- NBANK, 8, number of L2 banks
- DW, 32, data beat width
- BEATS, 17, beats per packet (beat 0 = ctag header)
- NCRED, 4, SIO packet buffers (initial credit count)

Ports:
- iol2clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l2b_req  in  NBANK  per-bank packet request, level, held until granted
- l2b_data  in  NBANK*DW  per-bank beat data, bank i at [i*DW +: DW]
- l2b_parity  in  NBANK*2  per-bank beat parity, bank i at [i*2 +: 2]
- l2b_ue_err  in  NBANK  per-bank uncorrectable-error flag for the current beat
- l2b_gnt  out  NBANK  one-hot grant; high for exactly BEATS consecutive cycles per packet
- sio_credit_ret  in  1  one buffer freed by SIO (single-cycle pulse)
- sio_vld  out  1  outbound beat valid
- sio_ctag_vld  out  1  outbound beat is header (beat 0)
- sio_data  out  DW  outbound beat data
- sio_parity  out  2  outbound beat parity
- sio_ue_err  out  1  outbound beat UE flag
- sio_bank  out  3  source bank of current beat
- cred_ovf  out  1  sticky: credit returned while count == NCRED
- proto_err  out  1  sticky: granted bank dropped req before its final beat

## Operation
- State machine: IDLE, XFER. Registers: state, winner[2:0], beat_cnt (0..BEATS-1), rr_ptr[2:0], cred_cnt (0..NCRED).
- Arbitration condition: any l2b_req and cred_cnt > 0. Winner = first requesting bank scanning rr_ptr, rr_ptr+1, … mod NBANK.
- IDLE: on arbitration condition, latch winner, beat_cnt <= 0, rr_ptr <= winner+1 mod NBANK, consume one credit, go XFER.
- XFER: l2b_gnt[winner] = 1; beat_cnt increments each cycle. At beat_cnt == BEATS-1: if arbitration condition (evaluated on current req, excluding nothing), start next packet back-to-back (no bubble) with the new winner; else go IDLE.
- Winner of the previous packet holds lowest priority via rr_ptr; a lone requester may win back-to-back.
- Granted bank drives beat k in the cycle its gnt is high with beat_cnt == k. Block registers l2b_data/parity/ue_err of winner into sio_* each gnt cycle; sio_ctag_vld = 1 for beat 0 only.
- Credits: -1 on packet start, +1 on sio_credit_ret; both in the same cycle: unchanged. Return at NCRED: count saturates, cred_ovf set.
- req deassertion by the granted bank mid-packet: transfer still completes all BEATS beats; proto_err set.
- sio_bank = winner of the beat being output.

## Timing
- Reset: state IDLE, rr_ptr 0, beat_cnt 0, cred_cnt NCRED, l2b_gnt 0, sio_vld/sio_ctag_vld/sio_ue_err 0, sio_data 0, sio_parity 0, sio_bank 0, cred_ovf 0, proto_err 0. Reset mid-packet aborts immediately; no partial beats after reset.
- l2b_gnt is registered: req sampled in cycle t → gnt from t+1 through t+BEATS.
- sio_* is one cycle after the gnt cycle carrying the same beat: req at t → sio_ctag_vld at t+2; last beat at t+BEATS+1.
- Back-to-back packets: continuous sio_vld, 2*BEATS cycles, ctag_vld at beat 0 of each.
- Credit returned in cycle t usable for arbitration in t+1.
- cred_cnt == 0: requests wait; no gnt until a credit arrives.

## Test plan
- Single req bank 3 from reset, cred 4 → l2b_gnt=8'h08 for 17 cycles starting 1 cycle after req; sio_ctag_vld 2 cycles after req, sio_bank=3, 17 sio_vld beats matching driven data; cred_cnt 3.
- All 8 banks request continuously, credits returned each packet → grants in order 0,1,…,7,0 with no idle cycles between packets.
- No credit returns, bank 0 requests 5 packets → 4 packets issued, 5th waits; one sio_credit_ret pulse → 5th starts next cycle.
- sio_credit_ret at cred_cnt==4 → cred_cnt stays 4, cred_ovf=1 until reset; simultaneous start+return at cred 2 → stays 2.
- Bank 5 drops req at beat 6 with ue_err on beat 9 → all 17 beats output, sio_ue_err only on beat 9, proto_err=1.
- reset asserted at beat 10 → next cycle all outputs at reset values, cred_cnt 4, rr_ptr 0.
